// File: rtl/rx_frame_fsm.sv
// UART receive framing FSM: qualifies the start bit, shifts in data LSB-first,
// checks optional parity and the stop bit, and presents each completed frame.
module rx_frame_fsm #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       AcqSig_i,
  input  logic       Rx_i,
  input  logic       Rx_Synch_i,
  output logic [4:0] State_o,
  output logic [7:0] Byte_o,
  output logic       Byte_valid_o,
  output logic       Parity_err_o,
  output logic       Frame_err_o
);

  typedef enum logic [4:0] {
    IDLE   = 5'b00000,
    START  = 5'b00001,
    DATA   = 5'b00010,
    PARITY = 5'b00100,
    STOP   = 5'b01000,
    DONE   = 5'b10000
  } state_t;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t     state, state_next;
  logic [3:0] strb_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       par_pend;
  logic       mid_hit;
  logic       end_hit;

  // Mid-bit strobe for the start bit, last strobe of a bit period elsewhere.
  assign mid_hit = AcqSig_i && (strb_cnt == 4'd7);
  assign end_hit = AcqSig_i && (strb_cnt == 4'd15);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (Rx_Synch_i) state_next = START;
      START:  if (mid_hit) state_next = Rx_i ? IDLE : DATA;
      DATA:   if (end_hit && (bit_cnt == LAST_BIT))
                state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (end_hit) state_next = STOP;
      STOP:   if (end_hit) state_next = DONE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobe counter restarts on every state change, so the strobe coinciding
  // with IDLE->START is never counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      strb_cnt     <= 4'd0;
      bit_cnt      <= 3'd0;
      shreg        <= 8'h00;
      par_pend     <= 1'b0;
      Byte_o       <= 8'h00;
      Parity_err_o <= 1'b0;
      Frame_err_o  <= 1'b0;
    end else begin
      if (state_next != state) strb_cnt <= 4'd0;
      else if (AcqSig_i)       strb_cnt <= strb_cnt + 4'd1;

      if (state == START && state_next == DATA) bit_cnt <= 3'd0;
      else if (state == DATA && end_hit)         bit_cnt <= bit_cnt + 3'd1;

      if (state == DATA && end_hit) shreg[bit_cnt] <= Rx_i;

      if (state == IDLE && Rx_Synch_i) par_pend <= 1'b0;
      else if (state == PARITY && end_hit)
        par_pend <= ((^shreg) ^ Rx_i) != 1'(PARITY_ODD);

      // Results load on the edge into DONE so they line up with the valid pulse.
      if (state == STOP && end_hit) begin
        Byte_o       <= shreg;
        Parity_err_o <= par_pend;
        Frame_err_o  <= ~Rx_i;
      end
    end
  end

  assign State_o      = state;
  assign Byte_valid_o = (state == DONE);

endmodule
